// File: rtl/zq_cal_pkg.sv
`default_nettype none
// ============================================================================
// Module   : zq_cal_pkg
// Purpose  : Shared widths, code type and search-FSM state encoding for the
//            ZQ calibration controller.
// Revision : 1.0  initial release
// ============================================================================
package zq_cal_pkg;

  // Calibration code width, tied to the PHY zq_config bus
  localparam int ZQ_W         = 7;
  // Idle-cycle counter width for the automatic recalibration timer
  localparam int RECAL_CNT_W  = 24;
  // Per-trial settle counter width (settle range 0..255)
  localparam int SETTLE_CNT_W = 8;
  // Bit-index width for the successive-approximation walk (6 down to 0)
  localparam int IDX_W        = 3;

  typedef logic [ZQ_W-1:0] zq_code_t;

  // Explicit state encodings; the enum below is built on them
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    SETTLE = ST_SETTLE,
    DONE   = ST_DONE
  } zq_cal_state_e;

endpackage
`default_nettype wire

// File: rtl/zq_recal_timer.sv
`default_nettype none
// ============================================================================
// Module   : zq_recal_timer
// Purpose  : Idle-cycle counter that raises a one-cycle trigger once INTERVAL
//            enabled cycles have elapsed since the last clear. INTERVAL=0
//            disables the trigger entirely.
// Revision : 1.0  initial release
// ============================================================================
module zq_recal_timer
  import zq_cal_pkg::*;
#(
  parameter int INTERVAL = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic trigger
);

  localparam bit                     TIMER_ON = (INTERVAL != 0);
  // Count value seen during the INTERVAL-th enabled cycle
  localparam logic [RECAL_CNT_W-1:0] LAST     = RECAL_CNT_W'(INTERVAL - 1);

  logic [RECAL_CNT_W-1:0] cnt_q;
  logic [RECAL_CNT_W-1:0] cnt_d;
  logic                   hit;

  // Trigger fires in the cycle where the INTERVAL-th enabled cycle is counted
  always_comb begin
    hit     = TIMER_ON && enable && (cnt_q == LAST);
    trigger = hit;
  end

  // Next-count: clear wins, a trigger restarts the count, otherwise count up
  always_comb begin
    cnt_d = cnt_q;
    if (clear || hit) begin
      cnt_d = '0;
    end else if (TIMER_ON && enable) begin
      cnt_d = cnt_q + RECAL_CNT_W'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/zq_cal_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : zq_cal_ctrl
// Purpose  : ZQ calibration controller. Runs a successive-approximation
//            search over zq_config (MSB first), settling before each
//            comparator sample, and keeps the largest code for which the
//            comparator reads 0. Supports request-driven and periodic
//            recalibration. All outputs are registered.
// Revision : 1.0  initial release
// ============================================================================
module zq_cal_ctrl
  import zq_cal_pkg::zq_code_t;
  import zq_cal_pkg::zq_cal_state_e;
  import zq_cal_pkg::IDLE;
  import zq_cal_pkg::SETTLE;
  import zq_cal_pkg::DONE;
  import zq_cal_pkg::SETTLE_CNT_W;
  import zq_cal_pkg::IDX_W;
#(
  parameter int       ZQ_W           = 7,
  parameter int       SETTLE_CYCLES  = 3,
  parameter zq_code_t ZQ_DEFAULT     = 7'd64,
  parameter int       RECAL_INTERVAL = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            comparator_out,
  output logic [ZQ_W-1:0] zq_config,
  output logic            zq_cal_en,
  output logic            busy,
  output logic            done,
  output logic [ZQ_W-1:0] zq_code,
  output logic            code_valid,
  output logic            sat_hi,
  output logic            sat_lo
);

  localparam logic [SETTLE_CNT_W-1:0] SETTLE_LOAD = SETTLE_CNT_W'(SETTLE_CYCLES);
  localparam logic [IDX_W-1:0]        IDX_TOP     = IDX_W'(ZQ_W - 1);
  localparam zq_code_t                TRIAL_INIT  = zq_code_t'(1) << (ZQ_W - 1);

  zq_cal_state_e            state_q, state_d;
  zq_code_t                 trial_q, trial_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [SETTLE_CNT_W-1:0]  cnt_q, cnt_d;
  zq_code_t                 zq_config_q, zq_config_d;
  zq_code_t                 zq_code_q, zq_code_d;
  logic                     zq_cal_en_q, zq_cal_en_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     code_valid_q, code_valid_d;
  logic                     sat_hi_q, sat_hi_d;
  logic                     sat_lo_q, sat_lo_d;

  zq_code_t                 trial_bit;
  zq_code_t                 trial_kept;
  logic                     go;
  logic                     recal_trig;
  logic                     recal_en;
  logic                     recal_clr;

  // Recal timer runs only while idle with a valid result; DONE restarts it
  always_comb begin
    recal_en  = (state_q == IDLE) && code_valid_q;
    recal_clr = (state_q == DONE);
  end

  zq_recal_timer #(
    .INTERVAL (RECAL_INTERVAL)
  ) u_recal_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (recal_clr),
    .enable  (recal_en),
    .trigger (recal_trig)
  );

  // Search FSM: trial/index/settle sequencing and result capture
  always_comb begin
    state_d      = state_q;
    trial_d      = trial_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    zq_code_d    = zq_code_q;
    code_valid_d = code_valid_q;
    sat_hi_d     = sat_hi_q;
    sat_lo_d     = sat_lo_q;

    // Manual request and recal trigger merge into a single start
    go         = start || recal_trig;
    trial_bit  = zq_code_t'(1) << idx_q;
    // Comparator high means the trial overshoots: drop the bit under test
    trial_kept = comparator_out ? (trial_q & ~trial_bit) : trial_q;

    unique case (state_q)
      // DONE behaves as IDLE for acceptance so a start sampled at the end of
      // the done cycle launches the next search immediately
      IDLE, DONE: begin
        if (go) begin
          state_d = SETTLE;
          trial_d = TRIAL_INIT;
          idx_d   = IDX_TOP;
          cnt_d   = SETTLE_LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      SETTLE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - SETTLE_CNT_W'(1);
        end else if (idx_q != '0) begin
          trial_d = trial_kept | (trial_bit >> 1);
          idx_d   = idx_q - IDX_W'(1);
          cnt_d   = SETTLE_LOAD;
        end else begin
          // Last bit resolved: publish the result in the same edge
          trial_d      = trial_kept;
          state_d      = DONE;
          zq_code_d    = trial_kept;
          code_valid_d = 1'b1;
          sat_hi_d     = &trial_kept;
          sat_lo_d     = (trial_kept == '0);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are computed from next-state values so they register cleanly
    busy_d      = (state_d == SETTLE);
    zq_cal_en_d = (state_d == SETTLE);
    done_d      = (state_d == DONE);
    if (state_d == SETTLE) begin
      zq_config_d = trial_d;
    end else if (code_valid_d) begin
      zq_config_d = zq_code_d;
    end else begin
      zq_config_d = ZQ_DEFAULT;
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      trial_q      <= '0;
      idx_q        <= '0;
      cnt_q        <= '0;
      zq_config_q  <= ZQ_DEFAULT;
      zq_code_q    <= '0;
      zq_cal_en_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      code_valid_q <= 1'b0;
      sat_hi_q     <= 1'b0;
      sat_lo_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      trial_q      <= trial_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      zq_config_q  <= zq_config_d;
      zq_code_q    <= zq_code_d;
      zq_cal_en_q  <= zq_cal_en_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      code_valid_q <= code_valid_d;
      sat_hi_q     <= sat_hi_d;
      sat_lo_q     <= sat_lo_d;
    end
  end

  // Port drive
  always_comb begin
    zq_config  = zq_config_q;
    zq_cal_en  = zq_cal_en_q;
    busy       = busy_q;
    done       = done_q;
    zq_code    = zq_code_q;
    code_valid = code_valid_q;
    sat_hi     = sat_hi_q;
    sat_lo     = sat_lo_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_zq_cal_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_zq_cal_ctrl
// Purpose  : Self-checking bench for zq_cal_ctrl. Three instances: defaults,
//            zero settle, and auto-recal every 100 idle cycles. Each has a
//            PHY comparator model (code > target).
// Revision : 1.0  initial release
// ============================================================================
module tb_zq_cal_ctrl;

  logic       clk = 1'b0;
  logic       rst    [3];
  logic       start  [3];
  logic [7:0] target [3];
  logic       cmp    [3];
  logic [6:0] cfg    [3];
  logic [6:0] code   [3];
  logic       en     [3];
  logic       busy   [3];
  logic       done   [3];
  logic       cv     [3];
  logic       shi    [3];
  logic       slo    [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // PHY comparator: 1 when the driven code exceeds the analog target
  assign cmp[0] = ({1'b0, cfg[0]} > target[0]);
  assign cmp[1] = ({1'b0, cfg[1]} > target[1]);
  assign cmp[2] = ({1'b0, cfg[2]} > target[2]);

  zq_cal_ctrl u_dut_def (
    .clk(clk), .rst(rst[0]), .start(start[0]), .comparator_out(cmp[0]),
    .zq_config(cfg[0]), .zq_cal_en(en[0]), .busy(busy[0]), .done(done[0]),
    .zq_code(code[0]), .code_valid(cv[0]), .sat_hi(shi[0]), .sat_lo(slo[0])
  );

  zq_cal_ctrl #(.SETTLE_CYCLES(0)) u_dut_fast (
    .clk(clk), .rst(rst[1]), .start(start[1]), .comparator_out(cmp[1]),
    .zq_config(cfg[1]), .zq_cal_en(en[1]), .busy(busy[1]), .done(done[1]),
    .zq_code(code[1]), .code_valid(cv[1]), .sat_hi(shi[1]), .sat_lo(slo[1])
  );

  zq_cal_ctrl #(.RECAL_INTERVAL(100)) u_dut_recal (
    .clk(clk), .rst(rst[2]), .start(start[2]), .comparator_out(cmp[2]),
    .zq_config(cfg[2]), .zq_cal_en(en[2]), .busy(busy[2]), .done(done[2]),
    .zq_code(code[2]), .code_valid(cv[2]), .sat_hi(shi[2]), .sat_lo(slo[2])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Pulse start on instance u and follow the search against a binary-search
  // model of the target. x1/x2 are extra start pulses (cycle numbers, -1 none).
  // Entered at a falling edge; returns at the falling edge after done.
  task automatic run_search(input int u, input int s, input int tgt,
                            input int x1, input int x2);
    int trials[7];
    int res;
    int t;
    int exp_d;
    int dcyc;
    int busy_bad;
    res = 0;
    for (int b = 6; b >= 0; b--) begin
      t = res + (1 << b);
      trials[6-b] = t;
      if (t <= tgt) res = t;
    end
    exp_d = 7 * (s + 1) + 1;

    target[u] = 8'(tgt);
    @(negedge clk);
    start[u] = 1'b1;
    @(negedge clk);
    start[u] = 1'b0;
    dcyc = 0;
    busy_bad = 0;
    for (int c = 1; c <= exp_d + 20 && dcyc == 0; c++) begin
      if (c > 1) @(negedge clk);
      start[u] = (c == x1) || (c == x2);
      if (done[u] === 1'b1) begin
        dcyc = c;
      end else begin
        if (busy[u] !== 1'b1 || en[u] !== 1'b1) busy_bad++;
        if ((c - 1) % (s + 1) == 0 && (c - 1) / (s + 1) < 7)
          chk($sformatf("u%0d_tgt%0d_trial%0d", u, tgt, (c - 1) / (s + 1)),
              32'(cfg[u]), 32'(trials[(c - 1) / (s + 1)]));
      end
    end
    start[u] = 1'b0;
    chk($sformatf("u%0d_tgt%0d_done_cycle", u, tgt), dcyc, exp_d);
    chk($sformatf("u%0d_tgt%0d_busy_gap", u, tgt), busy_bad, 0);
    if (dcyc != 0) begin
      chk($sformatf("u%0d_tgt%0d_code", u, tgt), 32'(code[u]), res);
      chk($sformatf("u%0d_tgt%0d_sat_hi", u, tgt), 32'(shi[u]), 32'(res == 127));
      chk($sformatf("u%0d_tgt%0d_sat_lo", u, tgt), 32'(slo[u]), 32'(res == 0));
      chk($sformatf("u%0d_tgt%0d_valid", u, tgt), 32'(cv[u]), 1);
      chk($sformatf("u%0d_tgt%0d_cfg_done", u, tgt), 32'(cfg[u]), res);
      chk($sformatf("u%0d_tgt%0d_busy_done", u, tgt), 32'(busy[u]), 0);
    end
    @(negedge clk);
    chk($sformatf("u%0d_tgt%0d_done_pulse", u, tgt), 32'(done[u]), 0);
    chk($sformatf("u%0d_tgt%0d_idle_busy", u, tgt), 32'(busy[u]), 0);
    chk($sformatf("u%0d_tgt%0d_cfg_hold", u, tgt), 32'(cfg[u]), res);
  endtask

  initial begin
    int bad;
    int dc;
    int u;
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1;
      start[i] = 1'b0;
      target[i] = 8'd0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;

    // Reset state
    chk("rst_cfg", 32'(cfg[0]), 64);
    chk("rst_en", 32'(en[0]), 0);
    chk("rst_busy", 32'(busy[0]), 0);
    chk("rst_done", 32'(done[0]), 0);
    chk("rst_code", 32'(code[0]), 0);
    chk("rst_valid", 32'(cv[0]), 0);
    chk("rst_sat", {30'd0, shi[0], slo[0]}, 0);
    chk("rst_cfg_recal", 32'(cfg[2]), 64);

    // Nominal, saturation, zero settle
    run_search(0, 3, 42, -1, -1);
    run_search(0, 3, 200, -1, -1);
    run_search(0, 3, 0, -1, -1);
    run_search(1, 0, 42, -1, -1);

    // Starts while busy are dropped, not queued
    run_search(0, 3, 42, 5, 28);

    // Reset in the middle of a search
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    target[0] = 8'd42;
    @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (11) @(negedge clk);
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    chk("midrst_cfg", 32'(cfg[0]), 64);
    chk("midrst_en", 32'(en[0]), 0);
    chk("midrst_busy", 32'(busy[0]), 0);
    chk("midrst_valid", 32'(cv[0]), 0);
    bad = 0;
    for (int c = 0; c < 40; c++) begin
      if (done[0] !== 1'b0 || busy[0] !== 1'b0) bad++;
      @(negedge clk);
    end
    chk("midrst_no_done", bad, 0);

    // Randomized targets on the default and zero-settle instances
    for (int n = 0; n < 8; n++) begin
      u = int'($urandom_range(0, 1));
      run_search(u, (u == 0) ? 3 : 0, int'($urandom_range(0, 255)), -1, -1);
    end

    // Automatic recalibration after 100 idle cycles
    run_search(2, 3, 42, -1, -1);
    target[2] = 8'd50;
    bad = 0;
    for (int k = 2; k <= 100; k++) begin
      @(negedge clk);
      if (busy[2] !== 1'b0) bad++;
    end
    chk("recal_idle_quiet", bad, 0);
    @(negedge clk);
    chk("recal_autostart", 32'(busy[2]), 1);
    chk("recal_cfg64", 32'(cfg[2]), 64);
    bad = 0;
    dc = 0;
    for (int c = 2; c <= 60 && dc == 0; c++) begin
      @(negedge clk);
      if (done[2] === 1'b1) dc = c;
      else if (code[2] !== 7'd42) bad++;
    end
    chk("recal_done_cycle", dc, 29);
    chk("recal_old_code", bad, 0);
    chk("recal_code", 32'(code[2]), 50);

    // Manual start landing on the same edge as the recal trigger
    repeat (99) @(negedge clk);
    run_search(2, 3, 50, -1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
